// File: rtl/latch_bist_pkg.sv
// ============================================================================
// Module      : latch_bist_pkg
// Description : State encoding and stimulus/expected tables for latch_bist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package latch_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int VEC_COUNT = 8;

    // Each entry is {reset, e, d}; listed from index 7 down to index 0.
    localparam logic [VEC_COUNT-1:0][2:0] VEC_ROM = {
        3'b111, 3'b001, 3'b010, 3'b001,
        3'b000, 3'b011, 3'b010, 3'b101
    };

    // Expected q per index, bit i belongs to vector i.
    localparam logic [VEC_COUNT-1:0] EXP_Q = 8'b0001_1100;

    // Pin state that keeps the latch under test held in reset.
    localparam logic [2:0] VEC_PARK = 3'b100;

endpackage

`default_nettype wire

// File: rtl/latch_bist.sv
// ============================================================================
// Module      : latch_bist
// Description : Self-checking stimulus engine for a gated D latch with reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_bist
    import latch_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_e,
    output logic             dut_reset,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_index
);

    localparam int               CNT_W         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       C_LAST_IDX    = 3'(VEC_COUNT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_inc;
    logic [CNT_W-1:0] r_cnt;
    logic [ERR_W-1:0] r_err;
    logic             r_fail_valid;
    logic [2:0]       r_fail_index;
    logic [2:0]       r_vec;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_check;
    logic             w_last;
    logic             w_mismatch;

    assign w_idx_inc  = r_idx + 3'd1;
    assign w_last     = (r_idx == C_LAST_IDX);
    assign w_mismatch = (dut_q != EXP_Q[r_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == C_SETTLE_LAST) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check      = 1'b1;
                w_next_state = w_last ? ST_DONE : ST_APPLY;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The vector is loaded on the edge that enters APPLY, so the pins already
    // show it during APPLY and stay stable through SETTLE and CHECK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_index <= 3'd0;
            r_vec        <= VEC_PARK;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_APPLY) || (w_next_state == ST_SETTLE)
                   || (w_next_state == ST_CHECK);
            r_done <= (w_next_state == ST_DONE);

            if (r_state == ST_APPLY) begin
                r_cnt <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_idx        <= 3'd0;
                r_err        <= '0;
                r_fail_valid <= 1'b0;
                r_fail_index <= 3'd0;
                r_vec        <= VEC_ROM[3'd0];
            end

            if (w_check) begin
                if (w_mismatch) begin
                    if (r_err != {ERR_W{1'b1}}) begin
                        r_err <= r_err + ERR_W'(1);
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_index <= r_idx;
                    end
                end
                if (w_last) begin
                    r_vec <= VEC_PARK;
                end else begin
                    r_idx <= w_idx_inc;
                    r_vec <= VEC_ROM[w_idx_inc];
                end
            end
        end
    end

    assign dut_reset  = r_vec[2];
    assign dut_e      = r_vec[1];
    assign dut_d      = r_vec[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_index = r_fail_index;

endmodule

`default_nettype wire
